// File: rtl/stream_arbiter_if.sv
// Requester-side and FIFO-side signals of stream_arbiter. The master side drives the requests.
// The slave side is the arbiter itself.
interface stream_arbiter_if #(
  parameter int NPORTS  = 4,
  parameter int WIDTH   = 8,
  parameter int SRCBITS = $clog2(NPORTS)
);
  logic [NPORTS*WIDTH-1:0] in_data;
  logic [NPORTS-1:0]       in_last;
  logic [NPORTS-1:0]       in_valid;
  logic [NPORTS-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_last;
  logic [SRCBITS-1:0]      out_src;
  logic                    out_valid;
  logic                    out_ready;
  logic [NPORTS-1:0]       trunc_err;
  logic [NPORTS-1:0]       err_clr;

  modport master (
    output in_data, in_last, in_valid, out_ready, err_clr,
    input  in_ready, out_data, out_last, out_src, out_valid, trunc_err
  );

  modport slave (
    input  in_data, in_last, in_valid, out_ready, err_clr,
    output in_ready, out_data, out_last, out_src, out_valid, trunc_err
  );
endinterface

// File: rtl/stream_arbiter.sv
// Round-robin, packet-locked arbiter merging NPORTS valid/ready streams onto one FIFO write port.
// A grant is held until the last beat, or until MAXLEN beats force the packet to end.
module stream_arbiter #(
  parameter int NPORTS  = 4,
  parameter int WIDTH   = 8,
  parameter int MAXLEN  = 256,
  parameter int SRCBITS = $clog2(NPORTS),
  parameter int LENBITS = $clog2(MAXLEN + 1)
) (
  input logic            clk,
  input logic            reset,
  stream_arbiter_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_nxt;
  logic [SRCBITS-1:0] grant, grant_nxt;
  logic [SRCBITS-1:0] rr_last, rr_last_nxt;
  logic [SRCBITS-1:0] pick, cand;
  logic [LENBITS-1:0] beats, beats_nxt;
  logic [NPORTS-1:0]  trunc_err, trunc_nxt;
  logic               found, at_max, accept, busy;

  // Scan rr_last+1, rr_last+2, ... so the most recently served port is considered last.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= NPORTS; i++) begin
      cand = SRCBITS'((int'(rr_last) + i) % NPORTS);
      if (!found && bus.in_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Reset gates the handshake combinationally so no beat slips through in a reset cycle.
  assign busy   = (state == BUSY) && !reset;
  assign at_max = (beats == LENBITS'(MAXLEN - 1));
  assign accept = bus.out_valid & bus.out_ready;

  assign bus.out_data  = bus.in_data[int'(grant)*WIDTH +: WIDTH];
  assign bus.out_last  = bus.in_last[grant] | at_max;
  assign bus.out_src   = grant;
  assign bus.out_valid = busy & bus.in_valid[grant];
  assign bus.trunc_err = trunc_err;

  always_comb begin
    bus.in_ready = '0;
    if (busy) bus.in_ready[grant] = bus.out_ready;
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    rr_last_nxt = rr_last;
    beats_nxt   = beats;
    trunc_nxt   = trunc_err & ~bus.err_clr;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = pick;
          beats_nxt = '0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (accept) begin
          if (bus.out_last) begin
            state_nxt   = IDLE;
            rr_last_nxt = grant;
            beats_nxt   = '0;
          end else begin
            beats_nxt = beats + LENBITS'(1);
          end
          // A forced end sets the flag after the clear so a simultaneous set wins.
          if (at_max && !bus.in_last[grant]) trunc_nxt[grant] = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      rr_last   <= SRCBITS'(NPORTS - 1);
      beats     <= '0;
      trunc_err <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      rr_last   <= rr_last_nxt;
      beats     <= beats_nxt;
      trunc_err <= trunc_nxt;
    end
  end
endmodule

// File: doc/stream_arbiter.md
# stream_arbiter

Round-robin, packet-locked arbiter that merges NPORTS valid/ready requester streams onto the single write port of a sync_fifo. It drives the FIFO's wr_data/wr_valid and honours its wr_ready. A grant is held until the requester's last beat is accepted, so packets never interleave. A per-grant beat limit prevents a requester that never sends last from monopolising the FIFO.

## Interface
- NPORTS, 4: number of requesters, 2..16.
- WIDTH, 8: data width per beat.
- MAXLEN, 256: maximum beats forwarded per grant, 1..65535.
- SRCBITS, $clog2(NPORTS): width of the source index (derived; do not override).
- LENBITS, $clog2(MAXLEN+1): width of the beat counter (derived).

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- in_data  in  NPORTS*WIDTH  port p occupies bits [p*WIDTH +: WIDTH].
- in_last  in  NPORTS  final beat of packet, per port.
- in_valid  in  NPORTS  beat offered, per port.
- in_ready  out  NPORTS  beat accepted when valid&ready, per port.
- out_data  out  WIDTH  to FIFO wr_data.
- out_last  out  1  packet end (in_last, or forced at MAXLEN).
- out_src  out  SRCBITS  index of granted port.
- out_valid  out  1  to FIFO wr_valid.
- out_ready  in  1  from FIFO wr_ready.
- trunc_err  out  NPORTS  sticky: port p had a grant force-ended at MAXLEN.
- err_clr  in  NPORTS  clears the corresponding trunc_err bits.

## Operation
- States: IDLE and BUSY. Registers: state, grant[SRCBITS], rr_last[SRCBITS], beats[LENBITS], trunc_err.
- IDLE:
  - out_valid=0 and in_ready=0.
  - If any in_valid is set, grant ← first p with in_valid[p], scanning rr_last+1, rr_last+2, … modulo NPORTS. Then beats ← 0 and state ← BUSY.
  - Otherwise remain in IDLE.
- BUSY, with g=grant:
  - out_valid=in_valid[g], out_data=in_data[g], out_src=g.
  - in_ready[g]=out_ready; all other in_ready bits are 0.
  - out_last=in_last[g] | (beats==MAXLEN-1).
- Beat accepted (out_valid&out_ready):
  - If out_last: state ← IDLE, rr_last ← g, beats ← 0.
  - Otherwise: beats ← beats+1.
  - If the beat was forced (beats==MAXLEN-1 and !in_last[g]): set trunc_err[g]. The port's remaining beats form a new packet on a later grant.
- A granted port that drops in_valid mid-packet keeps the grant; the arbiter waits indefinitely.
- The arbiter never inspects non-granted ports while in BUSY.
- trunc_err update precedence in one cycle: set wins over err_clr for the same bit.
- out_data, out_last and out_src are don't-care when out_valid=0. Drive them from grant anyway; do not gate them.

## Timing
- Reset values: state=IDLE, grant=0, rr_last=NPORTS-1 (so port 0 wins the first arbitration), beats=0, trunc_err=0.
- While reset=1: out_valid=0 and in_ready=0, combinationally gated. No beat transfers in that cycle.
- Reset asserted mid-packet: the packet is abandoned with no forced out_last. The downstream consumer owns recovery.
- Request to grant: 1 cycle. A request seen in IDLE at edge n allows the first beat to transfer in cycle n+1 at the earliest.
- Between packets: exactly one IDLE cycle (bubble). Peak throughput for P-beat packets is P/(P+1).
- In BUSY, the datapath is combinational from in_* to out_*. There are no registers in the data path; the FIFO provides the storage.
- Backpressure: out_ready=0 holds in_ready[g]=0. The requester must hold its data stable (standard valid/ready).
- MAXLEN=1: every beat is a separate grant. trunc_err is set for any beat with in_last=0.
- Round-robin fairness: with all ports continuously requesting, grants rotate 0,1,2,…,NPORTS-1,0,…. No port waits more than NPORTS-1 packets.
- out_src is stable for the whole packet.

## Test plan
- Reset then idle: hold reset 2 cycles with all in_valid=1. Required: out_valid=0 and in_ready=0 throughout. After release, grant goes to port 0 and the first beat transfers 2 cycles after reset falls.
- Fairness: NPORTS=4, all ports continuously send 3-beat packets with data 0xP0,0xP1,0xP2 and out_ready=1. Required: out_src sequence 0,1,2,3,0; each packet is contiguous with out_last on beat 3; one bubble cycle between packets.
- Lock and stall: port 2 sends 4 beats and drops in_valid for 5 cycles after beat 2, while port 1 is requesting. Required: port 2 completes all 4 beats before port 1 gets any in_ready.
- Backpressure: out_ready toggles 1,0,0,1 during a 2-beat packet. Required: beats transfer only on out_ready=1 cycles; data is unchanged while stalled.
- Truncation: MAXLEN=4, port 1 sends 6 beats with in_last only on beat 6. Required:
  - Beat 4 has out_last=1 and trunc_err[1]=1 from the next cycle.
  - Beats 5–6 form a later 2-beat packet.
  - err_clr[1] pulse clears the flag; a simultaneous set keeps it set.
- Mid-packet reset: reset asserted after beat 1 of 3. Required: state returns to IDLE and rr_last=NPORTS-1. The next grant goes to the lowest-index requester.
